// File: rtl/riscv_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package   : riscv_pkg                                                      |
// | Purpose   : RV32I shift-decode constants, shift-type encoding and the      |
// |             entry record carried from the issue stage to the shifter.      |
// | Ports     : n/a (package)                                                  |
// | Revision  : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
package riscv_pkg;

  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SR      = 3'b101;
  localparam logic [6:0] F7_LOGIC   = 7'b0000000;
  localparam logic [6:0] F7_ARITH   = 7'b0100000;

  // Shifter operation select; 2'b11 is never produced.
  typedef enum logic [1:0] {
    SH_SRL = 2'b00,
    SH_SLL = 2'b01,
    SH_SRA = 2'b10
  } shift_type_e;

  typedef struct packed {
    logic [31:0] a;
    logic [4:0]  shamt;
    shift_type_e stype;
    logic [4:0]  rd;
    logic        illegal;
  } shift_entry_t;

endpackage
`default_nettype wire

// File: rtl/skid_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module    : skid_buffer                                                    |
// | Purpose   : Generic 2-entry valid/ready buffer. Entry M drives the output, |
// |             entry S absorbs one beat of overflow so in_ready can be a      |
// |             pure register. Strict FIFO order, full throughput.             |
// | Ports     : clk, rst (sync, active-high), flush_i                          |
// |             in_valid_i / in_ready_o / in_data_i[W]   upstream handshake    |
// |             out_valid_o / out_ready_i / out_data_o[W] downstream handshake |
// | Revision  : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
module skid_buffer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush_i,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [W-1:0] in_data_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [W-1:0] out_data_o
);

  logic         m_valid_q, m_valid_d;
  logic         s_valid_q, s_valid_d;
  logic [W-1:0] m_data_q,  m_data_d;
  logic [W-1:0] s_data_q,  s_data_d;
  logic         w_accept;

  // Flush wins over a same-cycle accept.
  assign w_accept = in_valid_i && !s_valid_q && !flush_i;

  always_comb begin
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    s_valid_d = s_valid_q;
    s_data_d  = s_data_q;

    if (!m_valid_q || out_ready_i) begin
      // M is free this cycle: refill from S first to keep FIFO order.
      // in_ready is low whenever S is valid, so no accept can collide here.
      if (s_valid_q) begin
        m_valid_d = 1'b1;
        m_data_d  = s_data_q;
        s_valid_d = 1'b0;
      end else if (w_accept) begin
        m_valid_d = 1'b1;
        m_data_d  = in_data_i;
      end else begin
        m_valid_d = 1'b0;
      end
    end else if (w_accept) begin
      // M is stalled; park the new beat in S. M data is untouched so the
      // output holds steady under back-pressure.
      s_valid_d = 1'b1;
      s_data_d  = in_data_i;
    end

    if (flush_i) begin
      m_valid_d = 1'b0;
      s_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      m_valid_q <= 1'b0;
      s_valid_q <= 1'b0;
      m_data_q  <= '0;
      s_data_q  <= '0;
    end else begin
      m_valid_q <= m_valid_d;
      s_valid_q <= s_valid_d;
      m_data_q  <= m_data_d;
      s_data_q  <= s_data_d;
    end
  end

  assign in_ready_o  = !s_valid_q;
  assign out_valid_o = m_valid_q;
  assign out_data_o  = m_data_q;

endmodule
`default_nettype wire

// File: rtl/shift_issue_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module    : shift_issue_stage                                              |
// | Purpose   : Issue stage ahead of the barrel shifter. Decodes RV32I         |
// |             SLL/SRL/SRA and SLLI/SRLI/SRAI, picks the shift amount from    |
// |             rs2[4:0] or imm[24:20], and registers the result behind a      |
// |             2-entry skid buffer. Non-shift encodings flow with illegal=1.  |
// | Ports     : clk, rst (sync, active-high), flush                            |
// |             in_valid/in_ready, instr[32], rs1_data[XLEN], rs2_data[XLEN]   |
// |             out_valid/out_ready, sh_a[XLEN], sh_shamt[5], sh_type[2],      |
// |             sh_rd[RD_W], sh_illegal                                        |
// |             stat_issued/stat_stall[CNT_W] only with SHIFT_STATS_EN         |
// | Config    : `define SHIFT_STATS_EN adds transfer and stall counters.       |
// | Revision  : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
module shift_issue_stage
  import riscv_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int RD_W  = 5,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instr,
  input  logic [XLEN-1:0]  rs1_data,
  input  logic [XLEN-1:0]  rs2_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  sh_a,
  output logic [4:0]       sh_shamt,
  output logic [1:0]       sh_type,
  output logic [RD_W-1:0]  sh_rd,
  output logic             sh_illegal
`ifdef SHIFT_STATS_EN
  ,
  output logic [CNT_W-1:0] stat_issued,
  output logic [CNT_W-1:0] stat_stall
`endif
);

  // The entry record is fixed at 32-bit data / 5-bit rd.
  if (XLEN != 32 || RD_W != 5 || CNT_W < 1) begin : g_bad_params
    $error("shift_issue_stage: only XLEN=32, RD_W=5, CNT_W>=1 supported");
  end

  logic [6:0]   w_opcode;
  logic [2:0]   w_funct3;
  logic [6:0]   w_funct7;
  logic         w_is_imm;
  logic         w_is_reg;
  shift_entry_t w_entry;
  shift_entry_t w_out;
  logic         w_unused;

  assign w_opcode = instr[6:0];
  assign w_funct3 = instr[14:12];
  assign w_funct7 = instr[31:25];
  assign w_is_imm = (w_opcode == OPC_OP_IMM);
  assign w_is_reg = (w_opcode == OPC_OP);

  // rs1 index and the upper rs2 bits never influence the shifter command.
  assign w_unused = ^{instr[19:15], rs2_data[XLEN-1:5]};

  always_comb begin
    w_entry         = '0;
    w_entry.a       = rs1_data;
    w_entry.rd      = instr[11:7];
    w_entry.stype   = SH_SRL;
    w_entry.illegal = 1'b1;

    // The shift-immediate forms reuse funct7 as imm[11:5], so one table
    // covers both opcodes.
    if (w_is_imm || w_is_reg) begin
      if (w_funct3 == F3_SLL && w_funct7 == F7_LOGIC) begin
        w_entry.stype   = SH_SLL;
        w_entry.illegal = 1'b0;
      end else if (w_funct3 == F3_SR && w_funct7 == F7_LOGIC) begin
        w_entry.stype   = SH_SRL;
        w_entry.illegal = 1'b0;
      end else if (w_funct3 == F3_SR && w_funct7 == F7_ARITH) begin
        w_entry.stype   = SH_SRA;
        w_entry.illegal = 1'b0;
      end
    end

    // Illegal entries carry shamt=0 so a downstream trap sees a clean record.
    if (!w_entry.illegal) begin
      w_entry.shamt = w_is_imm ? instr[24:20] : rs2_data[4:0];
    end
  end

  skid_buffer #(
    .W ($bits(shift_entry_t))
  ) u_skid (
    .clk         (clk),
    .rst         (rst),
    .flush_i     (flush),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_data_i   (w_entry),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_data_o  (w_out)
  );

  assign sh_a       = w_out.a;
  assign sh_shamt   = w_out.shamt;
  assign sh_type    = w_out.stype;
  assign sh_rd      = w_out.rd;
  assign sh_illegal = w_out.illegal;

`ifdef SHIFT_STATS_EN
  logic [CNT_W-1:0] issued_q;
  logic [CNT_W-1:0] stall_q;

  // Flush leaves the counters alone; only rst clears them.
  always_ff @(posedge clk) begin
    if (rst) begin
      issued_q <= '0;
      stall_q  <= '0;
    end else begin
      if (out_valid && out_ready) begin
        issued_q <= issued_q + CNT_W'(1);
      end
      if (out_valid && !out_ready) begin
        stall_q <= stall_q + CNT_W'(1);
      end
    end
  end

  assign stat_issued = issued_q;
  assign stat_stall  = stall_q;
`endif

endmodule
`default_nettype wire
